// File: rtl/iq_dispatch_ctrl.sv
// Dispatch-side controller for the instruction queue: buffers decoded instructions in a
// small FIFO, feeds up to two queue dispatch ports, and sequences mispredict recovery.
module iq_dispatch_ctrl #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int QSLOTS     = 3,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [1:0]                    dec_valid,
    input  logic [DW-1:0]                 dec_data0,
    input  logic [DW-1:0]                 dec_data1,
    output logic                          dec_ready,
    input  logic                          mispredict,
    input  logic [QSLOTS-1:0]             qValid,
    output logic [1:0]                    iqLoads,
    output logic [DW-1:0]                 iq_data0,
    output logic [DW-1:0]                 iq_data1,
    output logic [QSLOTS-1:0]             flush,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int QW = $clog2(QSLOTS + 1);
    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_HOLD - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   hold_reg, hold_next;

    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   wr_ptr1, rd_ptr1;
    logic [CW-1:0]   push_n, pop_n;
    logic            push_en;
    logic            run;

    logic [QW-1:0]   qcnt [QSLOTS+1];
    logic [QW-1:0]   free;
    logic [DW-1:0]   mem_rd [FIFO_DEPTH];

    // Occupied queue slots as a running popcount chain.
    assign qcnt[0] = '0;
    generate
        for (genvar gi = 0; gi < QSLOTS; gi++) begin : g_qcnt
            assign qcnt[gi+1] = qcnt[gi] + QW'(qValid[gi]);
        end
    endgenerate
    assign free = QW'(QSLOTS) - qcnt[QSLOTS];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_RUN: begin
                if (mispredict) begin
                    state_next = ST_FLUSH;
                    hold_next  = HOLD_INIT;
                end
            end
            ST_FLUSH: begin
                if (mispredict) begin
                    hold_next = HOLD_INIT;
                end else if (hold_reg == '0) begin
                    state_next = ST_DRAIN;
                end else begin
                    hold_next = hold_reg - HW'(1);
                end
            end
            ST_DRAIN: begin
                if (mispredict) begin
                    state_next = ST_FLUSH;
                    hold_next  = HOLD_INIT;
                end else if (qValid == '0) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
                hold_next  = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run        = (state_reg == ST_RUN);
        busy       = !run;
        flush      = (state_reg == ST_FLUSH) ? '1 : '0;
        dec_ready  = run && (cnt_reg <= CW'(FIFO_DEPTH - 2));
        // Freed-this-cycle slots are ignored, so a load can never overflow the queue.
        iqLoads[0] = run && (cnt_reg != '0) && (free != '0);
        iqLoads[1] = run && (cnt_reg > CW'(1)) && (free > QW'(1));
    end

    // ---------------- FIFO bookkeeping ----------------
    assign push_en = dec_ready && dec_valid[0] && !mispredict;
    assign push_n  = push_en ? (dec_valid[1] ? CW'(2) : CW'(1)) : '0;
    assign pop_n   = CW'(iqLoads[0]) + CW'(iqLoads[1]);
    assign wr_ptr1 = wr_ptr_reg + PW'(1);
    assign rd_ptr1 = rd_ptr_reg + PW'(1);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        // Mispredict empties the FIFO and swallows any same-cycle push or pop.
        if (mispredict) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            cnt_next    = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PW'(push_n);
            rd_ptr_next = rd_ptr_reg + PW'(pop_n);
            cnt_next    = cnt_reg + push_n - pop_n;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DW-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push_en) begin
                    if (wr_ptr_reg == PW'(gi)) begin
                        entry_reg <= dec_data0;
                    end else if (dec_valid[1] && (wr_ptr1 == PW'(gi))) begin
                        entry_reg <= dec_data1;
                    end
                end
            end
            assign mem_rd[gi] = entry_reg;
        end
    endgenerate

    assign iq_data0 = mem_rd[rd_ptr_reg];
    assign iq_data1 = mem_rd[rd_ptr1];
    assign fifo_cnt = cnt_reg;

endmodule

// File: tb/tb_iq_dispatch_ctrl.sv
// Directed bench for iq_dispatch_ctrl: a vector table for push/dispatch behaviour and
// hand-written sequences for mispredict recovery and asynchronous reset.
module tb_iq_dispatch_ctrl;

    localparam int DW = 32;

    logic          clock;
    logic          rst_n;
    logic [1:0]    dec_valid;
    logic [DW-1:0] dec_data0;
    logic [DW-1:0] dec_data1;
    logic          dec_ready;
    logic          mispredict;
    logic [2:0]    qValid;
    logic [1:0]    iqLoads;
    logic [DW-1:0] iq_data0;
    logic [DW-1:0] iq_data1;
    logic [2:0]    flush;
    logic [2:0]    fifo_cnt;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    iq_dispatch_ctrl #(
        .DW(DW), .FIFO_DEPTH(4), .QSLOTS(3), .FLUSH_HOLD(2)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .dec_valid  (dec_valid),
        .dec_data0  (dec_data0),
        .dec_data1  (dec_data1),
        .dec_ready  (dec_ready),
        .mispredict (mispredict),
        .qValid     (qValid),
        .iqLoads    (iqLoads),
        .iq_data0   (iq_data0),
        .iq_data1   (iq_data1),
        .flush      (flush),
        .fifo_cnt   (fifo_cnt),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] A = 32'hA000_0001, B = 32'hB000_0002, C = 32'hC000_0003;
    localparam logic [31:0] D = 32'hD000_0004, E = 32'hE000_0005, F = 32'hF000_0006;
    localparam logic [31:0] G = 32'h1000_0007, H = 32'h2000_0008, I = 32'h3000_0009;
    localparam logic [31:0] J = 32'h4000_000A, K = 32'h5000_000B, L = 32'h6000_000C;
    localparam logic [31:0] M = 32'h7000_000D, N = 32'h8000_000E, V = 32'h9000_000F;
    localparam logic [31:0] W = 32'h9100_0010;

    typedef struct {
        logic [1:0]  dv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [2:0]  qv;
        logic [1:0]  e_ld;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        ck_d0;
        logic        ck_d1;
        logic        ck_rdy;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] dv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic mp, input logic [2:0] qv);
        dec_valid  = dv;
        dec_data0  = d0;
        dec_data1  = d1;
        mispredict = mp;
        qValid     = qv;
        #1;
    endtask

    // One cycle of a hand-written sequence: drive, check control outputs, advance.
    task automatic hs(input string name, input logic [1:0] dv, input logic [31:0] d0,
                      input logic [31:0] d1, input logic mp, input logic [2:0] qv,
                      input logic [2:0] e_flush, input logic e_busy, input logic [2:0] e_cnt,
                      input logic e_rdy, input logic [1:0] e_ld);
        drive(dv, d0, d1, mp, qv);
        $display("seq %s: flush=%b busy=%b cnt=%0d rdy=%b ld=%b", name, flush, busy,
                 fifo_cnt, dec_ready, iqLoads);
        chk({name, ".flush"},     32'(flush),     32'(e_flush));
        chk({name, ".busy"},      32'(busy),      32'(e_busy));
        chk({name, ".fifo_cnt"},  32'(fifo_cnt),  32'(e_cnt));
        chk({name, ".dec_ready"}, 32'(dec_ready), 32'(e_rdy));
        chk({name, ".iqLoads"},   32'(iqLoads),   32'(e_ld));
        @(negedge clock);
    endtask

    initial begin
        //            dv     d0 d1 qv      ld     rdy   cnt   e_d0 e_d1 ck0 ck1 ckr
        vecs[0]  = '{2'b11, A, B, 3'b000, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2'b00, 0, 0, 3'b000, 2'b11, 1'b1, 3'd2, A, B, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{2'b00, 0, 0, 3'b000, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, C, D, 3'b111, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, E, 0, 3'b111, 2'b00, 1'b1, 3'd2, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'b00, 0, 0, 3'b110, 2'b01, 1'b0, 3'd3, C, 0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, F, G, 3'b110, 2'b01, 1'b1, 3'd2, D, 0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{2'b01, H, 0, 3'b110, 2'b01, 1'b0, 3'd3, E, 0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, H, 0, 3'b110, 2'b01, 1'b1, 3'd2, F, 0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{2'b00, 0, 0, 3'b110, 2'b01, 1'b1, 3'd2, G, 0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 0, 0, 3'b110, 2'b01, 1'b1, 3'd1, H, 0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2'b00, 0, 0, 3'b110, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{2'b11, I, J, 3'b111, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{2'b11, K, L, 3'b111, 2'b00, 1'b1, 3'd2, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{2'b11, M, N, 3'b111, 2'b00, 1'b0, 3'd4, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{2'b10, M, N, 3'b111, 2'b00, 1'b0, 3'd4, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{2'b00, 0, 0, 3'b000, 2'b11, 1'b0, 3'd4, I, J, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{2'b00, 0, 0, 3'b000, 2'b11, 1'b1, 3'd2, K, L, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{2'b00, 0, 0, 3'b001, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{2'b10, M, N, 3'b111, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{2'b00, 0, 0, 3'b000, 2'b00, 1'b1, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1};

        // Reset state.
        rst_n = 1'b0;
        drive(2'b00, 0, 0, 1'b0, 3'b000);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset.iqLoads",   32'(iqLoads),   32'd0);
        chk("reset.flush",     32'(flush),     32'd0);
        chk("reset.dec_ready", 32'(dec_ready), 32'd1);
        chk("reset.fifo_cnt",  32'(fifo_cnt),  32'd0);
        chk("reset.busy",      32'(busy),      32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Table: push, dispatch, wrap, full, illegal dec_valid.
        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].dv, vecs[v].d0, vecs[v].d1, 1'b0, vecs[v].qv);
            $display("vec %0d: dv=%b qv=%b -> ld=%b rdy=%b cnt=%0d d0=%h d1=%h", v,
                     vecs[v].dv, vecs[v].qv, iqLoads, dec_ready, fifo_cnt, iq_data0, iq_data1);
            chk($sformatf("vec%0d.iqLoads", v),  32'(iqLoads),  32'(vecs[v].e_ld));
            chk($sformatf("vec%0d.fifo_cnt", v), 32'(fifo_cnt), 32'(vecs[v].e_cnt));
            chk($sformatf("vec%0d.flush", v),    32'(flush),    32'd0);
            chk($sformatf("vec%0d.busy", v),     32'(busy),     32'd0);
            if (vecs[v].ck_rdy)
                chk($sformatf("vec%0d.dec_ready", v), 32'(dec_ready), 32'(vecs[v].e_rdy));
            if (vecs[v].ck_d0)
                chk($sformatf("vec%0d.iq_data0", v), iq_data0, vecs[v].e_d0);
            if (vecs[v].ck_d1)
                chk($sformatf("vec%0d.iq_data1", v), iq_data1, vecs[v].e_d1);
            @(negedge clock);
        end

        // Mispredict with three entries buffered, single pulse.
        //   name   dv     d0 d1 mp    qv      flush   busy  cnt   rdy   ld
        hs("mp.a", 2'b11, A, B, 1'b0, 3'b111, 3'b000, 1'b0, 3'd0, 1'b1, 2'b00);
        hs("mp.b", 2'b01, C, 0, 1'b0, 3'b111, 3'b000, 1'b0, 3'd2, 1'b1, 2'b00);
        hs("mp.c", 2'b00, 0, 0, 1'b1, 3'b111, 3'b000, 1'b0, 3'd3, 1'b0, 2'b00);
        hs("mp.d", 2'b11, D, E, 1'b0, 3'b111, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("mp.e", 2'b00, 0, 0, 1'b0, 3'b111, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("mp.f", 2'b00, 0, 0, 1'b0, 3'b111, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("mp.g", 2'b00, 0, 0, 1'b0, 3'b111, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("mp.h", 2'b00, 0, 0, 1'b0, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("mp.i", 2'b00, 0, 0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b1, 2'b00);

        // Second pulse during FLUSH extends the flush window.
        hs("ext.a", 2'b00, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0, 3'd0, 1'b1, 2'b00);
        hs("ext.b", 2'b00, 0, 0, 1'b1, 3'b000, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("ext.c", 2'b00, 0, 0, 1'b0, 3'b000, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("ext.d", 2'b00, 0, 0, 1'b0, 3'b000, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("ext.e", 2'b00, 0, 0, 1'b0, 3'b000, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("ext.f", 2'b00, 0, 0, 1'b0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b1, 2'b00);

        // Mispredict from DRAIN re-enters FLUSH, then reset lands mid-FLUSH.
        hs("drn.a", 2'b00, 0, 0, 1'b1, 3'b111, 3'b000, 1'b0, 3'd0, 1'b1, 2'b00);
        hs("drn.b", 2'b00, 0, 0, 1'b0, 3'b111, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("drn.c", 2'b00, 0, 0, 1'b0, 3'b111, 3'b111, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("drn.d", 2'b00, 0, 0, 1'b0, 3'b111, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        hs("drn.e", 2'b00, 0, 0, 1'b1, 3'b111, 3'b000, 1'b1, 3'd0, 1'b0, 2'b00);
        drive(2'b00, 0, 0, 1'b0, 3'b111);
        chk("refl.flush", 32'(flush), 32'b111);
        chk("refl.busy",  32'(busy),  32'd1);
        // Asynchronous reset with no clock edge in between.
        rst_n = 1'b0;
        #1;
        $display("async reset: flush=%b busy=%b rdy=%b", flush, busy, dec_ready);
        chk("arst.flush",     32'(flush),     32'd0);
        chk("arst.busy",      32'(busy),      32'd0);
        chk("arst.dec_ready", 32'(dec_ready), 32'd1);
        chk("arst.fifo_cnt",  32'(fifo_cnt),  32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Normal operation resumes after reset.
        drive(2'b11, V, W, 1'b0, 3'b000);
        chk("post.fifo_cnt0", 32'(fifo_cnt), 32'd0);
        @(negedge clock);
        drive(2'b00, 0, 0, 1'b0, 3'b000);
        $display("post reset: ld=%b d0=%h d1=%h", iqLoads, iq_data0, iq_data1);
        chk("post.iqLoads",  32'(iqLoads), 32'b11);
        chk("post.iq_data0", iq_data0, V);
        chk("post.iq_data1", iq_data1, W);
        @(negedge clock);
        #1;
        chk("post.fifo_cnt", 32'(fifo_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
